rgb888_to_565_stream: RTL and testbench
=======================================

# rgb888_to_565_stream

Parametrised AXI-Stream pixel converter. Accepts beats of PIXELS_PER_BEAT pixels in 32-bit 0RGB888 words and emits beats of the same pixels in 16-bit RGB565, at full throughput with a registered, backpressure-safe output. Sits between the DMA read stream and the display/upscaler input path. Also checks frame length against a configured beat count.

## Interface
Parameters:
- PIXELS_PER_BEAT, 4: pixels per beat, 1..8.
- BEATS_PER_FRAME, 1024: expected input beats per frame, including the tlast beat; ≥2.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input ready.
- s_tlast  in  1  last beat of frame.
- rgb888_in  in  32*PIXELS_PER_BEAT  pixel i at [32i+23:32i] as R[23:16] G[15:8] B[7:0]; bits [32i+31:32i+24] ignored.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  tlast of the corresponding input beat, unmodified.
- rgb565_out  out  16*PIXELS_PER_BEAT  pixel i at [16i+15:16i] as {R5,G6,B5}.
- frame_err  out  1  sticky; set on any length mismatch.
- err_pulse  out  1  one-cycle pulse per mismatch event.

## Operation
- Conversion without rounding: R5=R8[7:3], G6=G8[7:2], B5=B8[7:3].
- Pixel order preserved; pixel 0 is least significant on both sides.
- Output stage is a 2-entry skid: main register (drives m_*) plus skid register.
- Accept when s_tvalid && s_tready. Converted data goes to main if main is empty or is draining this cycle; otherwise it goes to skid.
- On main drain (m_tvalid && m_tready), skid contents, if valid, move to main.
- s_tready = !skid_valid. The register is driven directly, with no combinational path from m_tready.
- Frame counter beat_cnt, width clog2(BEATS_PER_FRAME), counts accepted beats:
  - Accepted beat with s_tlast and beat_cnt != BEATS_PER_FRAME-1: early-last error; counter ← 0.
  - Accepted beat at beat_cnt == BEATS_PER_FRAME-1 without s_tlast: late-last error; counter ← 0.
  - Accepted beat with s_tlast at the expected count: normal; counter ← 0.
  - Otherwise the counter increments.
- On error, err_pulse is high the next cycle and frame_err is set. Only reset clears frame_err. Data and tlast pass through unchanged on error.

## Timing
- Reset values: s_tready=1 (after deassertion), m_tvalid=0, m_tlast=0, rgb565_out=0, frame_err=0, err_pulse=0, beat_cnt=0, skid empty.
- s_tready is 0 while aresetn=0.
- Latency: a beat accepted at edge N is on m_* after edge N, i.e. visible in cycle N+1.
- Throughput: 1 beat/cycle while m_tready=1.
- m_tready low with main full: the next accepted beat goes to skid and s_tready drops the following cycle. No beat is lost or duplicated.
- Simultaneous accept and drain with skid empty: the new beat replaces main and skid stays empty.
- m_tvalid/m_tdata/m_tlast are stable while m_tvalid && !m_tready.
- Reset mid-stream discards both registers and the counter immediately (asynchronously). No partial beat is emitted.

## Configuration
- RGB565_ROUND_EN defined: round-to-nearest with saturation.
  - R5=min(31,(R8+4)>>3), G6=min(63,(G8+2)>>2), B5=min(31,(B8+4)>>3).
  - Use 9-bit intermediate sums.
- RGB565_ROUND_EN undefined: truncation as in Operation. No adders are synthesised.
- Latency and handshake are identical in both builds.

## Structure
- Package rgb565_pkg holds:
  - RGB888_PX_W=32 and RGB565_PX_W=16.
  - Channel field offsets.
  - Function px888_to_565 (truncating or rounding under the macro).
- One sub-module: axis_skid_reg, the generic 2-entry skid register parametrised by data width. The top instantiates it with width 16*PIXELS_PER_BEAT+1 (data plus tlast).

## Test plan
- Primaries, PIXELS_PER_BEAT=4, m_tready=1: in 00FF0000_0000FF00_000000FF_00FFFFFF -> out F800_07E0_001F_FFFF one cycle after accept.
- Rounding: pixel 123456 -> 11AA (macro off) / 11AB (on); 7F7F7F -> 7BEF / 8410; 808080 -> 8410 in both builds; FCFEFC -> FFFF (saturation, on).
- Backpressure: 6 consecutive beats, m_tready low for 3 cycles mid-burst -> all 6 beats out in order, none dropped or duplicated; s_tready low exactly 1 cycle after the skid fills; outputs held stable while stalled.
- Frame length, BEATS_PER_FRAME=4:
  - tlast on beat 4 -> no error.
  - tlast on beat 2 -> err_pulse one cycle, frame_err=1; next frame counts from 0.
  - 4 beats without tlast -> late error.
- Reset mid-burst with main and skid full -> m_tvalid=0 and frame_err=0 immediately; first beat after reset appears normally with beat_cnt=0.
- PIXELS_PER_BEAT=1 and =8 builds: random 500-beat stream with random m_tready -> matches scoreboard model.

Source files
------------

// File: rtl/rgb565_pkg.sv
// Shared widths, channel field offsets and the per-pixel RGB888 -> RGB565 conversion.
// Latency: combinational helper only; no state.
// Backpressure: not applicable.
// Build option: RGB565_ROUND_EN selects round-to-nearest with saturation; default truncates.
package rgb565_pkg;

    localparam int RGB888_PX_W = 32;
    localparam int RGB565_PX_W = 16;

    // Byte offsets of each channel inside a 0RGB888 word.
    localparam int R8_LSB = 16;
    localparam int G8_LSB = 8;
    localparam int B8_LSB = 0;
    localparam int A8_LSB = 24;

    // Field offsets inside a {R5,G6,B5} word.
    localparam int R5_LSB = 11;
    localparam int G6_LSB = 5;
    localparam int B5_LSB = 0;

    function automatic logic [RGB565_PX_W-1:0] px888_to_565(input logic [RGB888_PX_W-1:0] px);
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
        logic [7:0] unused_alpha;
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
`ifdef RGB565_ROUND_EN
        logic [8:0] r_sum;
        logic [8:0] g_sum;
        logic [8:0] b_sum;
`endif
        r8           = px[R8_LSB +: 8];
        g8           = px[G8_LSB +: 8];
        b8           = px[B8_LSB +: 8];
        unused_alpha = px[A8_LSB +: 8];
`ifdef RGB565_ROUND_EN
        // Add half an output LSB; a carry into bit 8 means the rounded value
        // overflowed the field, so clamp to all-ones.
        r_sum = {1'b0, r8} + 9'd4;
        g_sum = {1'b0, g8} + 9'd2;
        b_sum = {1'b0, b8} + 9'd4;
        r5    = r_sum[8] ? 5'h1f : r_sum[7:3];
        g6    = g_sum[8] ? 6'h3f : g_sum[7:2];
        b5    = b_sum[8] ? 5'h1f : b_sum[7:3];
`else
        r5 = r8[7:3];
        g6 = g8[7:2];
        b5 = b8[7:3];
`endif
        return {r5, g6, b5};
    endfunction

endpackage

// File: rtl/rgb888_to_565_stream_if.sv
// Stream bundle for the converter: input beat, output beat and frame-length status.
// Latency: wiring only.
// Backpressure: s_tready/m_tready carry the valid-ready handshakes on each side.
// Modports: slave = converter view, master = source/sink (DMA side, display side) view.
interface rgb888_to_565_stream_if #(
    parameter int PIXELS_PER_BEAT = 4
);
    logic                                                   s_tvalid;
    logic                                                   s_tready;
    logic                                                   s_tlast;
    logic [rgb565_pkg::RGB888_PX_W*PIXELS_PER_BEAT-1:0]     rgb888_in;
    logic                                                   m_tvalid;
    logic                                                   m_tready;
    logic                                                   m_tlast;
    logic [rgb565_pkg::RGB565_PX_W*PIXELS_PER_BEAT-1:0]     rgb565_out;
    logic                                                   frame_err;
    logic                                                   err_pulse;

    modport slave (
        input  s_tvalid, s_tlast, rgb888_in, m_tready,
        output s_tready, m_tvalid, m_tlast, rgb565_out, frame_err, err_pulse
    );

    modport master (
        output s_tvalid, s_tlast, rgb888_in, m_tready,
        input  s_tready, m_tvalid, m_tlast, rgb565_out, frame_err, err_pulse
    );
endinterface

// File: rtl/axis_skid_reg.sv
// Generic 2-entry skid register: main register drives the output, skid catches one beat on stall.
// Latency: 1 cycle (input accepted at edge N is on o_* from edge N).
// Backpressure: o_rdy = !skid_valid, registered only; no combinational path from i_rdy.
// Ports: clk, rst_n (async active-low); i_vld/o_rdy/i_dat upstream; o_vld/i_rdy/o_dat downstream.
module axis_skid_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    output logic              o_rdy,
    input  logic [DATA_W-1:0] i_dat,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [DATA_W-1:0] o_dat
);
    logic              r_main_vld;
    logic [DATA_W-1:0] r_main_dat;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_dat;
    logic              w_acc;
    logic              w_drain;

    // Gating with rst_n keeps ready low for the whole reset window, and the
    // release does not have to wait a clock edge.
    assign o_rdy   = rst_n & ~r_skid_vld;
    assign w_acc   = i_vld & o_rdy;
    assign w_drain = r_main_vld & i_rdy;
    assign o_vld   = r_main_vld;
    assign o_dat   = r_main_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_vld <= 1'b0;
            r_main_dat <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
        end else if (w_drain) begin
            // Skid full implies o_rdy was low, so no new beat competes with it.
            if (r_skid_vld) begin
                r_main_dat <= r_skid_dat;
                r_main_vld <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_acc) begin
                r_main_dat <= i_dat;
                r_main_vld <= 1'b1;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_acc) begin
            if (!r_main_vld) begin
                r_main_dat <= i_dat;
                r_main_vld <= 1'b1;
            end else begin
                r_skid_dat <= i_dat;
                r_skid_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb888_to_565_stream.sv
// Converts beats of 0RGB888 pixels to RGB565 and checks frame length against BEATS_PER_FRAME.
// Latency: 1 cycle accept-to-output; 1 beat/cycle while m_tready is high.
// Backpressure: 2-entry skid output; s_tready drops the cycle after the skid fills.
// Ports: aclk, aresetn (async active-low), bus (slave modport: s_* in, m_* out, frame_err, err_pulse).
// Build option: RGB565_ROUND_EN selects rounding conversion (see rgb565_pkg).
module rgb888_to_565_stream
    import rgb565_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 4,
    parameter int BEATS_PER_FRAME = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    rgb888_to_565_stream_if.slave bus
);
    localparam int OUT_W  = RGB565_PX_W * PIXELS_PER_BEAT;
    localparam int SKID_W = OUT_W + 1;
    localparam int CNT_W  = (BEATS_PER_FRAME > 2) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS_PER_FRAME - 1);

    logic [OUT_W-1:0]  w_px565;
    logic              w_s_rdy;
    logic              w_m_vld;
    logic [SKID_W-1:0] w_m_dat;
    logic              w_acc;
    logic              w_at_end;
    logic              w_len_err;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_frame_err;
    logic              r_err_pulse;

    always_comb begin
        w_px565 = '0;
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            w_px565[i*RGB565_PX_W +: RGB565_PX_W] =
                px888_to_565(bus.rgb888_in[i*RGB888_PX_W +: RGB888_PX_W]);
        end
    end

    // tlast rides as the top bit of the skid word so it stays aligned with its pixels.
    axis_skid_reg #(
        .DATA_W (SKID_W)
    ) u_skid (
        .clk   (aclk),
        .rst_n (aresetn),
        .i_vld (bus.s_tvalid),
        .o_rdy (w_s_rdy),
        .i_dat ({bus.s_tlast, w_px565}),
        .o_vld (w_m_vld),
        .i_rdy (bus.m_tready),
        .o_dat (w_m_dat)
    );

    assign bus.s_tready   = w_s_rdy;
    assign bus.m_tvalid   = w_m_vld;
    assign bus.m_tlast    = w_m_dat[SKID_W-1];
    assign bus.rgb565_out = w_m_dat[OUT_W-1:0];

    // Early last (tlast before the final slot) and late last (final slot
    // without tlast) both reduce to tlast disagreeing with the slot position.
    assign w_acc     = bus.s_tvalid & w_s_rdy;
    assign w_at_end  = (r_beat_cnt == LAST_IDX);
    assign w_len_err = w_acc & (bus.s_tlast ^ w_at_end);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_cnt  <= '0;
            r_frame_err <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_len_err;
            if (w_len_err) begin
                r_frame_err <= 1'b1;
            end
            if (w_acc) begin
                // Either kind of error resynchronises to a fresh frame.
                if (bus.s_tlast || w_at_end) begin
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.frame_err = r_frame_err;
    assign bus.err_pulse = r_err_pulse;

endmodule

// File: tb/tb_rgb888_to_565_stream.sv
// Bench for rgb888_to_565_stream: directed scenarios plus a random stream on 1/4/8-pixel builds.
// Latency: expects outputs one cycle after accept.
// Backpressure: random and scheduled m_tready; occupancy model predicts s_tready and m_tvalid.
module tb_rgb888_to_565_stream;

    localparam int BPF = 4;
    localparam int NRAND = 500;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tvld = 1'b0;
    logic         tlast = 1'b0;
    logic         tready = 1'b1;
    logic [255:0] pix_all = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rgb888_to_565_stream_if #(.PIXELS_PER_BEAT(1)) bus1 ();
    rgb888_to_565_stream_if #(.PIXELS_PER_BEAT(4)) bus4 ();
    rgb888_to_565_stream_if #(.PIXELS_PER_BEAT(8)) bus8 ();

    assign bus1.s_tvalid  = tvld;
    assign bus1.s_tlast   = tlast;
    assign bus1.rgb888_in = pix_all[31:0];
    assign bus1.m_tready  = tready;
    assign bus4.s_tvalid  = tvld;
    assign bus4.s_tlast   = tlast;
    assign bus4.rgb888_in = pix_all[127:0];
    assign bus4.m_tready  = tready;
    assign bus8.s_tvalid  = tvld;
    assign bus8.s_tlast   = tlast;
    assign bus8.rgb888_in = pix_all;
    assign bus8.m_tready  = tready;

    rgb888_to_565_stream #(.PIXELS_PER_BEAT(1), .BEATS_PER_FRAME(BPF)) u_dut1 (
        .aclk(clk), .aresetn(rst_n), .bus(bus1.slave));
    rgb888_to_565_stream #(.PIXELS_PER_BEAT(4), .BEATS_PER_FRAME(BPF)) u_dut4 (
        .aclk(clk), .aresetn(rst_n), .bus(bus4.slave));
    rgb888_to_565_stream #(.PIXELS_PER_BEAT(8), .BEATS_PER_FRAME(BPF)) u_dut8 (
        .aclk(clk), .aresetn(rst_n), .bus(bus8.slave));

    // Reference conversion from the channel rules, in integer arithmetic.
    function automatic logic [15:0] ref565(input logic [31:0] px);
        int r, g, b;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
`ifdef RGB565_ROUND_EN
        r = (r + 4) / 8; if (r > 31) r = 31;
        g = (g + 2) / 4; if (g > 63) g = 63;
        b = (b + 4) / 8; if (b > 31) b = 31;
`else
        r = r / 8;
        g = g / 4;
        b = b / 8;
`endif
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    function automatic logic [127:0] ref_beat(input logic [255:0] px);
        logic [127:0] o;
        logic [31:0]  w;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            w = px[32*i +: 32];
            o[16*i +: 16] = ref565(w);
        end
        return o;
    endfunction

    function automatic logic [255:0] rand_pix();
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    // Leaves the bench aligned 1 time unit after a rising edge.
    task automatic apply_reset();
        tvld = 1'b0; tlast = 1'b0; tready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic drive_beat(input logic [255:0] px, input logic last);
        int w;
        pix_all = px; tlast = last; tvld = 1'b1; w = 0;
        @(negedge clk);
        while (!bus4.s_tready && w < 50) begin w++; @(negedge clk); end
        n_tests++;
        if (!bus4.s_tready) begin
            n_fail++;
            $display("FAIL drive_timeout: s_tready=%b after %0d cycles, required 1", bus4.s_tready, w);
        end
        @(posedge clk); #1;
        tvld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tvld = 1'b0; tready = 1'b1;
        #3;
        n_tests++; if (bus4.s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_in_tready: got %b want 0", bus4.s_tready); end
        n_tests++; if (bus4.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_in_tvalid: got %b want 0", bus4.m_tvalid); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (bus4.s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_tready: got %b want 1", bus4.s_tready); end
        n_tests++; if (bus4.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", bus4.m_tvalid); end
        n_tests++; if (bus4.m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b want 0", bus4.m_tlast); end
        n_tests++; if (bus4.rgb565_out !== 64'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus4.rgb565_out); end
        n_tests++; if (bus4.frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b want 0", bus4.frame_err); end
        n_tests++; if (bus4.err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulse: got %b want 0", bus4.err_pulse); end
    endtask

    task automatic test_primaries();
        logic [255:0] px;
        apply_reset();
        px = '0;
        px[127:0] = 128'h00FF0000_0000FF00_000000FF_00FFFFFF;
        drive_beat(px, 1'b1);
        n_tests++; if (bus4.m_tvalid !== 1'b1) begin n_fail++; $display("FAIL prim_valid: got %b want 1", bus4.m_tvalid); end
        n_tests++; if (bus4.rgb565_out !== 64'hF800_07E0_001F_FFFF) begin n_fail++; $display("FAIL prim_data: got %h want F80007E0001FFFFF", bus4.rgb565_out); end
        n_tests++; if (bus4.m_tlast !== 1'b1) begin n_fail++; $display("FAIL prim_tlast: got %b want 1", bus4.m_tlast); end
        @(posedge clk); #1;
        n_tests++; if (bus4.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL prim_drained: got %b want 0", bus4.m_tvalid); end
    endtask

    task automatic test_rounding();
        logic [255:0] px;
        logic [63:0]  want;
`ifdef RGB565_ROUND_EN
        want = 64'hFFFF_8410_8410_11AB;
`else
        want = 64'hFFFF_8410_7BEF_11AA;
`endif
        apply_reset();
        px = '0;
        // Non-zero top bytes must not leak into the result.
        px[127:0] = 128'hAAFCFEFC_55808080_FF7F7F7F_12123456;
        drive_beat(px, 1'b0);
        n_tests++; if (bus4.rgb565_out !== want) begin n_fail++; $display("FAIL round_data: got %h want %h", bus4.rgb565_out, want); end
        n_tests++; if (bus1.rgb565_out !== want[15:0]) begin n_fail++; $display("FAIL round_px1: got %h want %h", bus1.rgb565_out, want[15:0]); end
    endtask

    task automatic test_backpressure();
        logic [255:0] beats[6];
        logic [63:0]  exp_out[6];
        logic [127:0] tmp;
        logic [64:0]  held;
        logic         held_v, acc, drn;
        int           sent, rcv, occ, low_seen;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            beats[i] = rand_pix();
            tmp = ref_beat(beats[i]);
            exp_out[i] = tmp[63:0];
        end
        sent = 0; rcv = 0; occ = 0; low_seen = 0; held_v = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            tready = !(cyc >= 2 && cyc <= 4);
            if (!tvld && sent < 6) begin tvld = 1'b1; pix_all = beats[sent]; tlast = (sent == 5); end
            @(negedge clk);
            n_tests++; if (bus4.s_tready !== (occ < 2)) begin n_fail++; $display("FAIL bp_tready cyc%0d: got %b want %b", cyc, bus4.s_tready, occ < 2); end
            n_tests++; if (bus4.m_tvalid !== (occ > 0)) begin n_fail++; $display("FAIL bp_tvalid cyc%0d: got %b want %b", cyc, bus4.m_tvalid, occ > 0); end
            if (held_v) begin
                n_tests++;
                if ({bus4.m_tlast, bus4.rgb565_out} !== held) begin n_fail++; $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, {bus4.m_tlast, bus4.rgb565_out}, held); end
            end
            if (!bus4.s_tready) low_seen++;
            acc = tvld && bus4.s_tready;
            drn = bus4.m_tvalid && tready;
            held_v = bus4.m_tvalid && !tready;
            held = {bus4.m_tlast, bus4.rgb565_out};
            if (drn) begin
                n_tests++;
                if (rcv >= 6) begin
                    n_fail++; $display("FAIL bp_extra: got beat %0d want at most 6", rcv + 1);
                end else if (bus4.rgb565_out !== exp_out[rcv] || bus4.m_tlast !== (rcv == 5)) begin
                    n_fail++; $display("FAIL bp_data beat%0d: got %h/%b want %h/%b", rcv, bus4.rgb565_out, bus4.m_tlast, exp_out[rcv], rcv == 5);
                end
                rcv++;
            end
            occ = occ + int'(acc) - int'(drn);
            if (acc) sent++;
            @(posedge clk); #1;
            if (acc) tvld = 1'b0;
        end
        tready = 1'b1;
        n_tests++; if (rcv != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", rcv); end
        // Skid fills at the stall's first edge; ready stays low through the two
        // remaining stall cycles and the first drain cycle.
        n_tests++; if (low_seen != 3) begin n_fail++; $display("FAIL bp_ready_low: got %0d cycles want 3", low_seen); end
    endtask

    task automatic test_frame_len();
        // Good frame, early last on beat 2, good frame, four beats without last, good frame.
        logic lasts[18] = '{0,0,0,1, 0,1, 0,0,0,1, 0,0,0,0, 0,0,0,1};
        logic exp_pulse, exp_sticky;
        int   cnt;
        apply_reset();
        cnt = 0; exp_sticky = 1'b0;
        for (int i = 0; i < 18; i++) begin
            exp_pulse = (lasts[i] != (cnt == BPF - 1));
            cnt = (lasts[i] || cnt == BPF - 1) ? 0 : cnt + 1;
            if (exp_pulse) exp_sticky = 1'b1;
            drive_beat(rand_pix(), lasts[i]);
            n_tests++; if (bus4.err_pulse !== exp_pulse) begin n_fail++; $display("FAIL len_pulse beat%0d: got %b want %b", i, bus4.err_pulse, exp_pulse); end
            n_tests++; if (bus4.frame_err !== exp_sticky) begin n_fail++; $display("FAIL len_sticky beat%0d: got %b want %b", i, bus4.frame_err, exp_sticky); end
        end
        @(posedge clk); #1;
        n_tests++; if (bus4.err_pulse !== 1'b0) begin n_fail++; $display("FAIL len_pulse_idle: got %b want 0", bus4.err_pulse); end
    endtask

    task automatic test_reset_midburst();
        logic [255:0] px;
        logic [127:0] tmp;
        apply_reset();
        drive_beat(rand_pix(), 1'b1);  // early last -> sticky error
        n_tests++; if (bus4.frame_err !== 1'b1) begin n_fail++; $display("FAIL mid_pre_err: got %b want 1", bus4.frame_err); end
        tready = 1'b0;
        drive_beat(rand_pix(), 1'b0);  // lands in skid
        n_tests++; if (bus4.s_tready !== 1'b0) begin n_fail++; $display("FAIL mid_full: s_tready got %b want 0", bus4.s_tready); end
        #1; rst_n = 1'b0; #1;
        n_tests++; if (bus4.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid: got %b want 0", bus4.m_tvalid); end
        n_tests++; if (bus4.frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_frame_err: got %b want 0", bus4.frame_err); end
        @(negedge clk); rst_n = 1'b1; tready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (bus4.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_no_leak: got %b want 0", bus4.m_tvalid); end
        for (int i = 0; i < BPF; i++) begin
            px = rand_pix();
            tmp = ref_beat(px);
            drive_beat(px, i == BPF - 1);
            n_tests++; if (bus4.m_tvalid !== 1'b1 || bus4.rgb565_out !== tmp[63:0]) begin n_fail++; $display("FAIL mid_after beat%0d: got %b/%h want 1/%h", i, bus4.m_tvalid, bus4.rgb565_out, tmp[63:0]); end
            n_tests++; if (bus4.err_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_cnt beat%0d: err_pulse got %b want 0", i, bus4.err_pulse); end
        end
    endtask

    task automatic test_random();
        logic [128:0] q1[$], q4[$], q8[$];
        logic [128:0] e;
        logic         acc, exp_err, exp_sticky;
        int           sent, rcv1, rcv4, rcv8, occ, cnt;
        apply_reset();
        sent = 0; rcv1 = 0; rcv4 = 0; rcv8 = 0; occ = 0; cnt = 0;
        exp_err = 1'b0; exp_sticky = 1'b0;
        for (int cyc = 0; cyc < 6000 && rcv4 < NRAND; cyc++) begin
            if (!tvld && sent < NRAND && $urandom_range(0, 3) != 0) begin
                tvld = 1'b1; pix_all = rand_pix(); tlast = ($urandom_range(0, 5) == 0);
            end
            tready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            n_tests++; if (bus4.s_tready !== (occ < 2)) begin n_fail++; $display("FAIL rnd_tready cyc%0d: got %b want %b", cyc, bus4.s_tready, occ < 2); end
            n_tests++; if (bus4.m_tvalid !== (occ > 0)) begin n_fail++; $display("FAIL rnd_tvalid cyc%0d: got %b want %b", cyc, bus4.m_tvalid, occ > 0); end
            n_tests++; if (bus4.err_pulse !== exp_err) begin n_fail++; $display("FAIL rnd_err cyc%0d: got %b want %b", cyc, bus4.err_pulse, exp_err); end
            exp_err = 1'b0;
            if (bus1.m_tvalid && tready) begin
                n_tests++;
                if (q1.size() == 0) begin n_fail++; $display("FAIL rnd_px1_extra: got beat with empty model"); end
                else begin e = q1.pop_front(); if (bus1.rgb565_out !== e[15:0] || bus1.m_tlast !== e[128]) begin n_fail++; $display("FAIL rnd_px1 beat%0d: got %h/%b want %h/%b", rcv1, bus1.rgb565_out, bus1.m_tlast, e[15:0], e[128]); end end
                rcv1++;
            end
            if (bus4.m_tvalid && tready) begin
                n_tests++;
                if (q4.size() == 0) begin n_fail++; $display("FAIL rnd_px4_extra: got beat with empty model"); end
                else begin e = q4.pop_front(); if (bus4.rgb565_out !== e[63:0] || bus4.m_tlast !== e[128]) begin n_fail++; $display("FAIL rnd_px4 beat%0d: got %h/%b want %h/%b", rcv4, bus4.rgb565_out, bus4.m_tlast, e[63:0], e[128]); end end
                rcv4++;
                occ--;
            end
            if (bus8.m_tvalid && tready) begin
                n_tests++;
                if (q8.size() == 0) begin n_fail++; $display("FAIL rnd_px8_extra: got beat with empty model"); end
                else begin e = q8.pop_front(); if (bus8.rgb565_out !== e[127:0] || bus8.m_tlast !== e[128]) begin n_fail++; $display("FAIL rnd_px8 beat%0d: got %h/%b want %h/%b", rcv8, bus8.rgb565_out, bus8.m_tlast, e[127:0], e[128]); end end
                rcv8++;
            end
            e = {tlast, ref_beat(pix_all)};
            if (tvld && bus1.s_tready) q1.push_back(e);
            if (tvld && bus8.s_tready) q8.push_back(e);
            acc = tvld && bus4.s_tready;
            if (acc) begin
                q4.push_back(e);
                occ++;
                sent++;
                exp_err = (tlast != (cnt == BPF - 1));
                cnt = (tlast || cnt == BPF - 1) ? 0 : cnt + 1;
                if (exp_err) exp_sticky = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) tvld = 1'b0;
        end
        tready = 1'b1;
        n_tests++; if (rcv4 != NRAND || rcv1 != NRAND || rcv8 != NRAND) begin n_fail++; $display("FAIL rnd_count: got %0d/%0d/%0d want %0d each", rcv1, rcv4, rcv8, NRAND); end
        n_tests++; if (bus4.frame_err !== exp_sticky) begin n_fail++; $display("FAIL rnd_sticky: got %b want %b", bus4.frame_err, exp_sticky); end
    endtask

    initial begin
        test_reset();
        test_primaries();
        test_rounding();
        test_backpressure();
        test_frame_len();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
